// File: rtl/conv1d_row_stream_pkg.sv
// conv1d_row_stream_pkg: shared state enum, default sizes and helpers
// for the streaming 1D convolution row.
package conv1d_row_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } conv1d_state_e;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_K_MAX   = 4;
  localparam int DEF_LEN_MAX = 64;

  // Number of outputs a row produces for a given configuration.
  function automatic int out_count(
    input int len,
    input int pad,
    input int k,
    input int stride
  );
    int l;
    l = len + 2 * pad;
    if (k <= 0 || stride <= 0 || l < k) return 0;
    return (l - k) / stride + 1;
  endfunction

endpackage

// File: rtl/conv1d_row_stream_conv_tap_mac.sv
// conv_tap_mac: one signed tap multiplier with an enable mask.
// Ports: i_en (tap active), i_a/i_b (signed samples), o_p (product or 0).
module conv_tap_mac #(
  parameter int DATA_W = 8
) (
  input  logic                     i_en,
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic signed [2*DATA_W-1:0] o_p
);

  logic signed [2*DATA_W-1:0] w_m;

  assign w_m = i_a * i_b;
  assign o_p = i_en ? w_m : '0;

endmodule

// File: rtl/conv1d_row_stream.sv
// conv1d_row_stream: one 1D conv row with run-time k/stride/pad, streamed
// through valid/ready handshakes (weights in, features in, pixels out).
// Ports: clk, rstn (async active-low), start + cfg_* (row setup),
//   w_valid/w_ready/w_data (weights, tap 0 first),
//   f_valid/f_ready/f_data (features, index 0 first),
//   o_valid/o_ready/o_data (signed output pixel), busy, cfg_err.
// Build option: CONV1D_ROW_RELU_EN clamps o_data to max(sum, 0).
module conv1d_row_stream
  import conv1d_row_stream_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int K_MAX   = DEF_K_MAX,
  parameter int LEN_MAX = DEF_LEN_MAX,
  parameter int ACC_W   = 2 * DATA_W + $clog2(K_MAX)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic [$clog2(K_MAX+1)-1:0]   cfg_k,
  input  logic [1:0]                   cfg_stride,
  input  logic [$clog2(K_MAX)-1:0]     cfg_pad,
  input  logic [$clog2(LEN_MAX+1)-1:0] cfg_len,
  input  logic                         w_valid,
  output logic                         w_ready,
  input  logic [DATA_W-1:0]            w_data,
  input  logic                         f_valid,
  output logic                         f_ready,
  input  logic [DATA_W-1:0]            f_data,
  output logic                         o_valid,
  input  logic                         o_ready,
  output logic [ACC_W-1:0]             o_data,
  output logic                         busy,
  output logic                         cfg_err
);

  localparam int KW  = $clog2(K_MAX + 1);
  localparam int PW  = $clog2(K_MAX);
  localparam int LW  = $clog2(LEN_MAX + 1);
  localparam int PSW = LW + 1;
  localparam int CW  = PSW + 1;

  conv1d_state_e r_state;

  logic [KW-1:0]  r_k;
  logic [KW-1:0]  r_widx;
  logic [1:0]     r_stride;
  logic [1:0]     r_ph;
  logic [PSW-1:0] r_p;
  logic [PSW-1:0] r_km1;
  logic [PSW-1:0] r_lm1;
  logic [PSW-1:0] r_dlo;
  logic [PSW-1:0] r_dhi;
  logic           r_w_ready;
  logic           r_cfg_err;
  logic           r_o_valid;

  logic signed [ACC_W-1:0]  r_o_data;
  logic signed [DATA_W-1:0] r_w [K_MAX];
  logic signed [DATA_W-1:0] r_s [K_MAX];

  logic [CW-1:0] w_cfg_l;
  logic          w_cfg_bad;
  logic          w_go;
  logic          w_wfire;
  logic          w_in_stream;
  logic          w_is_pad;
  logic          w_adv_ok;
  logic          w_step;
  logic          w_emit;
  logic [K_MAX-1:0] w_tap_en;

  logic signed [DATA_W-1:0]   w_new;
  logic signed [DATA_W-1:0]   w_nx [K_MAX];
  logic signed [2*DATA_W-1:0] w_prod [K_MAX];
  logic signed [ACC_W-1:0]    w_sum;
  logic signed [ACC_W-1:0]    w_res;

  // Padded row length, checked against k before a row is accepted.
  assign w_cfg_l = CW'(cfg_len) + (CW'(cfg_pad) << 1);

  assign w_cfg_bad = (cfg_k == '0)
                  || (cfg_k > KW'(K_MAX))
                  || (cfg_stride == 2'd0)
                  || (KW'(cfg_pad) >= cfg_k)
                  || (cfg_len == '0)
                  || (w_cfg_l < CW'(cfg_k));

  assign w_go    = (r_state == IDLE) && start && !w_cfg_bad;
  assign w_wfire = (r_state == LOAD_W) && r_w_ready && w_valid;

  assign w_in_stream = (r_state == STREAM);
  assign w_is_pad    = (r_p < r_dlo) || (r_p >= r_dhi);
  assign w_adv_ok    = !r_o_valid || o_ready;
  assign w_step      = w_in_stream && w_adv_ok
                    && (w_is_pad || f_valid);
  assign w_emit      = (r_p >= r_km1) && (r_ph == 2'd0);
  assign w_new       = w_is_pad ? '0 : f_data;

  // r_s[0] is the newest sample; the MACs see the window as it will
  // be after this cycle's shift so the pixel registers on that edge.
  always_comb begin
    w_nx[0] = w_new;
    for (int i = 1; i < K_MAX; i++) begin
      w_nx[i] = r_s[i-1];
    end
  end

  // Weights are stored reversed (tap j at k-1-j) so that slot i pairs
  // with r_s[i] directly, with no window mux on k.
  for (genvar g = 0; g < K_MAX; g++) begin : g_tap
    assign w_tap_en[g] = KW'(g) < r_k;
    conv_tap_mac #(
      .DATA_W(DATA_W)
    ) u_mac (
      .i_en(w_tap_en[g]),
      .i_a (w_nx[g]),
      .i_b (r_w[g]),
      .o_p (w_prod[g])
    );
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < K_MAX; i++) begin
      w_sum = w_sum + ACC_W'(w_prod[i]);
    end
  end

`ifdef CONV1D_ROW_RELU_EN
  assign w_res = w_sum[ACC_W-1] ? '0 : w_sum;
`else
  assign w_res = w_sum;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_k       <= '0;
      r_widx    <= '0;
      r_stride  <= '0;
      r_ph      <= '0;
      r_p       <= '0;
      r_km1     <= '0;
      r_lm1     <= '0;
      r_dlo     <= '0;
      r_dhi     <= '0;
      r_w_ready <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start && w_cfg_bad) begin
            r_cfg_err <= 1'b1;
          end else if (w_go) begin
            r_k       <= cfg_k;
            r_stride  <= cfg_stride;
            r_widx    <= cfg_k - KW'(1);
            r_km1     <= PSW'(cfg_k) - PSW'(1);
            r_lm1     <= PSW'(w_cfg_l - CW'(1));
            r_dlo     <= PSW'(cfg_pad);
            r_dhi     <= PSW'(cfg_pad) + PSW'(cfg_len);
            r_p       <= '0;
            r_ph      <= '0;
            r_w_ready <= 1'b1;
            r_state   <= LOAD_W;
          end
        end
        LOAD_W: begin
          if (w_wfire) begin
            if (r_widx == '0) begin
              r_w_ready <= 1'b0;
              r_state   <= STREAM;
            end else begin
              r_widx <= r_widx - KW'(1);
            end
          end
        end
        STREAM: begin
          if (w_step) begin
            // Stride phase only runs once the window is full.
            if (r_p >= r_km1) begin
              r_ph <= (r_ph == r_stride - 2'd1)
                    ? 2'd0 : r_ph + 2'd1;
            end
            if (r_p == r_lm1) begin
              r_state <= DRAIN;
            end else begin
              r_p <= r_p + PSW'(1);
            end
          end
        end
        DRAIN: begin
          if (w_adv_ok) r_state <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < K_MAX; i++) begin
        r_w[i] <= '0;
        r_s[i] <= '0;
      end
      r_o_valid <= 1'b0;
      r_o_data  <= '0;
    end else begin
      // Clearing on row start makes unused taps read as zero.
      if (w_go) begin
        for (int i = 0; i < K_MAX; i++) begin
          r_w[i] <= '0;
          r_s[i] <= '0;
        end
      end
      if (w_wfire) begin
        for (int i = 0; i < K_MAX; i++) begin
          if (KW'(i) == r_widx) r_w[i] <= w_data;
        end
      end
      if (w_step) begin
        for (int i = 0; i < K_MAX; i++) begin
          r_s[i] <= w_nx[i];
        end
      end
      if (w_step && w_emit) begin
        r_o_valid <= 1'b1;
        r_o_data  <= w_res;
      end else if (o_ready) begin
        r_o_valid <= 1'b0;
      end
    end
  end

  assign w_ready = r_w_ready;
  assign f_ready = w_in_stream && !w_is_pad && w_adv_ok;
  assign o_valid = r_o_valid;
  assign o_data  = r_o_data;
  assign busy    = (r_state != IDLE);
  assign cfg_err = r_cfg_err;

endmodule

// File: tb/tb_conv1d_row_stream.sv
// tb_conv1d_row_stream: directed rows checked against an arithmetic
// model of the padded strided convolution, plus literal expectations.
module tb_conv1d_row_stream;

  localparam int DATA_W  = 8;
  localparam int K_MAX   = 4;
  localparam int LEN_MAX = 64;
  localparam int ACC_W   = 2 * DATA_W + $clog2(K_MAX);

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic [2:0]        cfg_k = '0;
  logic [1:0]        cfg_stride = '0;
  logic [1:0]        cfg_pad = '0;
  logic [6:0]        cfg_len = '0;
  logic              w_valid = 1'b0;
  logic              w_ready;
  logic [DATA_W-1:0] w_data = '0;
  logic              f_valid = 1'b0;
  logic              f_ready;
  logic [DATA_W-1:0] f_data = '0;
  logic              o_valid;
  logic              o_ready = 1'b1;
  logic [ACC_W-1:0]  o_data;
  logic              busy;
  logic              cfg_err;

  conv1d_row_stream dut (
    .clk(clk), .rstn(rstn), .start(start),
    .cfg_k(cfg_k), .cfg_stride(cfg_stride),
    .cfg_pad(cfg_pad), .cfg_len(cfg_len),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .f_valid(f_valid), .f_ready(f_ready), .f_data(f_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
    .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int tw [K_MAX];
  int tf [LEN_MAX];
  int exp_q [$];
  int got_q [$];
  logic prev_hold = 1'b0;
  logic [ACC_W-1:0] prev_data = '0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic int relu(input int v);
`ifdef CONV1D_ROW_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Expected pixels straight from the definition of a padded,
  // strided correlation over the row.
  task automatic build_model(input int k, input int s,
                             input int pad, input int len);
    int l;
    int sum;
    int idx;
    int x;
    exp_q.delete();
    l = len + 2 * pad;
    for (int j = 0; j * s + k <= l; j++) begin
      sum = 0;
      for (int i = 0; i < k; i++) begin
        idx = j * s + i - pad;
        x = (idx >= 0 && idx < len) ? tf[idx] : 0;
        sum += x * tw[i];
      end
      exp_q.push_back(relu(sum));
    end
  endtask

  // Output monitor: every accepted pixel is compared to the model,
  // and a stalled pixel must stay put with features blocked.
  always begin
    @(negedge clk);
    if (rstn) begin
      if (prev_hold) begin
        chk("hold_valid", int'(o_valid), 1);
        chk("hold_data", $signed(o_data), $signed(prev_data));
      end
      if (o_valid && !o_ready) chk("stall_f_ready", int'(f_ready), 0);
      if (o_valid && o_ready) begin
        int v;
        v = $signed(o_data);
        got_q.push_back(v);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_output actual=%0d required=none", v);
        end else begin
          chk("o_data", v, exp_q.pop_front());
        end
      end
      prev_hold = o_valid && !o_ready;
      prev_data = o_data;
    end else begin
      prev_hold = 1'b0;
    end
  end

  // mode 0: o_ready=1, 1: stall 5 cycles at first pixel, 2: 2-of-3.
  task automatic run_row(input int k, input int s, input int pad,
                         input int len, input int mode,
                         input int abort_f);
    int wi, fi, stall_left, cyc;
    bit stalled, done, aborted, wf, ff;
    build_model(k, s, pad, len);
    got_q.delete();
    @(negedge clk);
    cfg_k = 3'(k);
    cfg_stride = 2'(s);
    cfg_pad = 2'(pad);
    cfg_len = 7'(len);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wi = 0; fi = 0; stall_left = 0; stalled = 0;
    done = 0; aborted = 0;
    w_valid = 1'b1;
    w_data = DATA_W'(tw[0]);
    f_valid = 1'b1;
    f_data = DATA_W'(tf[0]);
    o_ready = 1'b1;
    for (cyc = 0; cyc < 400 && !done && !aborted; cyc++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1;
      end else begin
        wf = w_valid && w_ready;
        ff = f_valid && f_ready;
        @(posedge clk);
        #1;
        if (wf) wi++;
        if (ff) fi++;
        w_valid = (wi < k);
        w_data = (wi < k) ? DATA_W'(tw[wi]) : '0;
        f_valid = (fi < len);
        f_data = (fi < len) ? DATA_W'(tf[fi]) : '0;
        if (mode == 1 && !stalled && o_valid) begin
          stall_left = 5;
          stalled = 1;
        end
        if (mode == 1) begin
          o_ready = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end else if (mode == 2) begin
          o_ready = (cyc % 3 != 0);
        end else begin
          o_ready = 1'b1;
        end
        if (abort_f > 0 && fi >= abort_f) aborted = 1;
      end
    end
    if (!aborted) begin
      w_valid = 1'b0;
      f_valid = 1'b0;
      o_ready = 1'b1;
      if (!done) begin
        checks++;
        failures++;
        $display("FAIL timeout row k=%0d busy=%0d required=0", k, busy);
      end else begin
        chk("w_count", wi, k);
        chk("f_count", fi, len);
        chk("exp_left", exp_q.size(), 0);
      end
    end
  endtask

  task automatic chk_out(input string nm, input int n,
                         input int e0, input int e1, input int e2);
    int e;
    chk({nm, "_n"}, got_q.size(), n);
    for (int i = 0; i < n; i++) begin
      e = (i == 0) ? e0 : (i == 1) ? e1 : e2;
      chk(nm, (i < got_q.size()) ? got_q[i] : 32'h7fffffff, e);
    end
  endtask

  task automatic err_start(input int k, input int pad);
    @(negedge clk);
    cfg_k = 3'(k);
    cfg_pad = 2'(pad);
    cfg_stride = 2'd1;
    cfg_len = 7'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("cfg_err_pulse", int'(cfg_err), 1);
    chk("cfg_err_busy", int'(busy), 0);
    chk("cfg_err_w_ready", int'(w_ready), 0);
    @(negedge clk);
    chk("cfg_err_clear", int'(cfg_err), 0);
    chk("cfg_err_idle", int'(busy), 0);
    chk("cfg_err_no_w", int'(w_ready), 0);
  endtask

  task automatic set_t1();
    tw[0] = 1; tw[1] = 2; tw[2] = 3;
    for (int i = 0; i < 5; i++) tf[i] = i + 1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_valid", int'(o_valid), 0);
    chk("rst_o_data", $signed(o_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_w_ready", int'(w_ready), 0);
    chk("rst_f_ready", int'(f_ready), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    @(negedge clk);
    rstn = 1'b1;

    set_t1();
    run_row(3, 1, 0, 5, 0, 0);
    chk_out("t1", 3, relu(14), relu(20), relu(26));

    tw[0] = 1; tw[1] = 1; tw[2] = 1;
    for (int i = 0; i < 4; i++) tf[i] = i + 1;
    run_row(3, 2, 1, 4, 0, 0);
    chk_out("t2", 2, relu(3), relu(9), 0);

    set_t1();
    run_row(3, 1, 0, 5, 1, 0);
    chk_out("t3", 3, relu(14), relu(20), relu(26));

    tw[0] = -1; tw[1] = 2;
    tf[0] = 3; tf[1] = -4;
    run_row(2, 1, 0, 2, 0, 0);
    chk_out("t4", 1, relu(-11), 0, 0);

    tw[0] = 2; tw[1] = -3; tw[2] = 1; tw[3] = 4;
    tf[0] = 5; tf[1] = -1; tf[2] = 7; tf[3] = 0;
    tf[4] = -8; tf[5] = 3; tf[6] = 2;
    run_row(4, 3, 2, 7, 2, 0);
    chk_out("t_pad2_s3", 3, relu(1), relu(-55), relu(-23));

    for (int i = 0; i < 4; i++) begin
      tw[i] = -128;
      tf[i] = -128;
    end
    run_row(4, 1, 0, 4, 0, 0);
    chk_out("t_max", 1, relu(65536), 0, 0);

    err_start(0, 0);
    err_start(3, 3);

    set_t1();
    run_row(3, 1, 0, 5, 0, 3);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_o_valid", int'(o_valid), 0);
    chk("mid_rst_o_data", $signed(o_data), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_f_ready", int'(f_ready), 0);
    chk("mid_rst_w_ready", int'(w_ready), 0);
    w_valid = 1'b0;
    f_valid = 1'b0;
    o_ready = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    set_t1();
    run_row(3, 1, 0, 5, 0, 0);
    chk_out("t6", 3, relu(14), relu(20), relu(26));

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv1d_row_stream.md
Name: conv1d_row_stream

Overview:
Parametrised successor to the fixed 4-PE stride-2 conv row. It computes one 1D convolution row of a LeViT conv stem layer with run-time kernel size, stride and zero-padding, and streams inputs and outputs through valid/ready handshakes. It sits between the feature-row SRAM reader and the psum accumulator, one instance per output channel lane.

Parameters:
DATA_W, 8, signed width of feature and weight samples
K_MAX, 4, maximum kernel taps (number of MAC taps instantiated)
LEN_MAX, 64, maximum input row length
ACC_W, 2*DATA_W+$clog2(K_MAX), signed output/accumulator width

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse in IDLE; latches cfg_* and begins a row
cfg_k  in  $clog2(K_MAX+1)  kernel taps, legal 1..K_MAX
cfg_stride  in  2  stride, legal 1..3
cfg_pad  in  $clog2(K_MAX)  zeros inserted before and after the row, legal 0..cfg_k-1
cfg_len  in  $clog2(LEN_MAX+1)  input samples, legal 1..LEN_MAX
w_valid  in  1  weight valid
w_ready  out  1  high only in LOAD_W
w_data  in  DATA_W  weight, tap 0 first
f_valid  in  1  feature valid
f_ready  out  1  feature accept
f_data  in  DATA_W  feature sample, index 0 first
o_valid  out  1  output valid
o_ready  in  1  output accept
o_data  out  ACC_W  signed output pixel
busy  out  1  high in any state except IDLE
cfg_err  out  1  one-cycle pulse on an illegal start

Behaviour:
- Reset: FSM to IDLE; window, weights, counters and o_data zeroed; w_ready, f_ready, o_valid, busy and cfg_err all 0.
- FSM states: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE: on start, configuration is checked.
  - Illegal configuration (cfg_k=0, cfg_k>K_MAX, cfg_stride=0, cfg_pad>=cfg_k, cfg_len=0, or cfg_len+2*cfg_pad<cfg_k): pulse cfg_err next cycle and stay IDLE.
  - Otherwise go to LOAD_W.
  - start outside IDLE is ignored.
- LOAD_W: w_ready=1. Accept exactly cfg_k weights into w[0..cfg_k-1]; taps >= cfg_k read as 0. Then go to STREAM.
- STREAM: a padded position counter p runs 0..L-1, where L=cfg_len+2*cfg_pad.
  - Pad positions (p<cfg_pad, or p>=cfg_pad+cfg_len) shift a 0 into the window without consuming input; f_ready=0 on those cycles.
  - Data positions: f_ready=1 when the advance condition holds; the sample shifts in on f_valid&&f_ready.
  - Window W holds the last cfg_k samples, W[0] oldest.
  - Output condition: after the shift at position p, if p>=cfg_k-1 and (p-(cfg_k-1)) mod cfg_stride == 0, register o_data = sum over i<cfg_k of W[i]*w[i] (signed, full ACC_W) and set o_valid the next cycle. Latency is 1 cycle from the completing shift.
- Advance condition (backpressure): the position advances only when !o_valid || o_ready. While an output is held, pads stall and f_ready=0.
- Output count: N=(L-cfg_k)/cfg_stride+1, floor division. Trailing positions after the last output are still consumed.
- DRAIN: entered when p reaches L-1. Wait until the final o_valid is accepted, then go to DONE.
- DONE: one cycle, then IDLE.
- o_valid/o_data stay stable until o_ready; no output is dropped or duplicated.
- Reset mid-operation: immediate return to the reset state; partial outputs are discarded.

Optional Feature:
CONV1D_ROW_RELU_EN:
- When defined, o_data = max(sum, 0).
- When undefined, o_data is the raw signed sum.
- Handshake and latency are unchanged in both cases.

Decomposition:
- Package definition: conv1d_state_e enum; constants for default DATA_W and K_MAX; function out_count(len, pad, k, stride).
- One sub-module, conv_tap_mac: a signed DATA_W×DATA_W multiply with a tap-enable mask, instantiated K_MAX times. The adder tree and output register stay in the top.

Test Plan:
1. k=3, s=1, pad=0, len=5, w={1,2,3}, f={1,2,3,4,5}, o_ready=1 -> o_data 14,20,26, then DONE, busy falls.
2. k=3, s=2, pad=1, len=4, w={1,1,1}, f={1,2,3,4} -> exactly 2 outputs: 3, 9.
3. Test 1 with o_ready held 0 for 5 cycles after the first o_valid -> o_data=14 held stable, f_ready=0 throughout, outputs still 14,20,26.
4. k=2, w={-1,2}, f={3,-4}, s=1, pad=0 -> o_data=-11; with CONV1D_ROW_RELU_EN defined -> 0.
5. start with cfg_k=0, then with cfg_pad=3/cfg_k=3 -> cfg_err pulses, no w_ready, state stays IDLE.
6. rstn low mid-STREAM of test 1 -> all outputs 0 asynchronously; a fresh test-1 run afterwards gives 14,20,26.
